uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between an RX echo path and an accelerator print stream.
// Echo bytes are held in a single-entry register. Ties are broken round-robin.
// An echoed CR can be followed by an LF, and no print byte is sent between them.
module uart_tx_arbiter #(
    parameter bit ECHO_CRLF   = 1'b1,
    parameter bit PRINT_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] echo_data,
    input  logic       echo_valid,
    input  logic [7:0] print_data,
    input  logic       print_valid,
    output logic       print_ready,
    output logic       tx_wr,
    output logic [7:0] tx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       busy,
    output logic       echo_overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StLfIssue,
        StLfWait
    } state_e;

    localparam logic [7:0] CharCr = 8'h0D;
    localparam logic [7:0] CharLf = 8'h0A;

    state_e     state_q, state_d;
    logic       echo_pend_q, echo_pend_d;
    logic [7:0] echo_buf_q, echo_buf_d;
    logic       echo_overrun_q, echo_overrun_d;
    // 1: print was granted last, 0: echo was granted last
    logic       last_grant_q, last_grant_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    // The frame in flight is an echoed CR that still owes an LF
    logic       lf_due_q, lf_due_d;

    logic       grant_echo;
    logic       grant_print;

    // Arbitration: grant only from IDLE with the transmitter quiet
    always_comb begin
        grant_echo  = 1'b0;
        grant_print = 1'b0;
        if (state_q == StIdle && !tx_active && !rst) begin
            if (echo_pend_q && print_valid) begin
                // Round-robin: the side not served last wins the tie
                if (last_grant_q) begin
                    grant_echo = 1'b1;
                end else begin
                    grant_print = 1'b1;
                end
            end else if (echo_pend_q) begin
                grant_echo = 1'b1;
            end else if (print_valid) begin
                grant_print = 1'b1;
            end
        end
    end

    // Echo holding register; a strobe arriving while the slot is full is dropped
    always_comb begin
        echo_pend_d    = echo_pend_q;
        echo_buf_d     = echo_buf_q;
        echo_overrun_d = echo_overrun_q;
        if (echo_valid) begin
            // The slot frees up in the same cycle its byte is granted
            if (!echo_pend_q || grant_echo) begin
                echo_buf_d  = echo_data;
                echo_pend_d = 1'b1;
            end else begin
                echo_overrun_d = 1'b1;
            end
        end else if (grant_echo) begin
            echo_pend_d = 1'b0;
        end
    end

    // Frame sequencing FSM: next state, latched byte and round-robin bookkeeping
    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        last_grant_d = last_grant_q;
        lf_due_d     = lf_due_q;
        unique case (state_q)
            StIdle: begin
                if (grant_echo || grant_print) begin
                    state_d      = StIssue;
                    tx_byte_d    = grant_echo ? echo_buf_q : print_data;
                    last_grant_d = grant_print;
                    lf_due_d     = ECHO_CRLF && grant_echo && (echo_buf_q == CharCr);
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (lf_due_q) begin
                        state_d   = StLfIssue;
                        tx_byte_d = CharLf;
                        lf_due_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLfIssue: begin
                state_d = StLfWait;
            end
            StLfWait: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            echo_pend_q    <= 1'b0;
            echo_buf_q     <= 8'h00;
            echo_overrun_q <= 1'b0;
            // Point "last" at the side that must lose the first tie
            last_grant_q   <= ~PRINT_FIRST;
            tx_byte_q      <= 8'h00;
            lf_due_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            echo_pend_q    <= echo_pend_d;
            echo_buf_q     <= echo_buf_d;
            echo_overrun_q <= echo_overrun_d;
            last_grant_q   <= last_grant_d;
            tx_byte_q      <= tx_byte_d;
            lf_due_q       <= lf_due_d;
        end
    end

    // Outputs; strobes are forced low while reset is asserted
    always_comb begin
        print_ready  = grant_print;
        tx_wr        = !rst && (state_q == StIssue || state_q == StLfIssue);
        tx_byte      = tx_byte_q;
        busy         = !rst && (state_q != StIdle || echo_pend_q || print_valid);
        echo_overrun = echo_overrun_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level reference model predicts every
// frame (byte and tx_wr cycle). A separate monitor pops those predictions when
// the DUT strobes tx_wr. The monitor also checks print_ready, busy and overrun
// on every cycle.
module tb_uart_tx_arbiter;
    parameter bit ECHO_CRLF   = 1'b1;
    parameter bit PRINT_FIRST = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] echo_data, print_data, tx_byte;
    logic       echo_valid, print_valid, print_ready, tx_wr;
    logic       tx_active, tx_done, busy, echo_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_arbiter #(
        .ECHO_CRLF  (ECHO_CRLF),
        .PRINT_FIRST(PRINT_FIRST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo_data   (echo_data),
        .echo_valid  (echo_valid),
        .print_data  (print_data),
        .print_valid (print_valid),
        .print_ready (print_ready),
        .tx_wr       (tx_wr),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .busy        (busy),
        .echo_overrun(echo_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: a frame lasts ulen cycles after tx_wr; done on the last one
    int   ucnt = 0;
    int   umin = 2;
    int   umax = 6;
    logic ext_active = 1'b0;
    logic spur_done  = 1'b0;
    always @(posedge clk) begin
        if (tx_wr) ucnt <= $urandom_range(umax, umin);
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign tx_active = (ucnt != 0) || ext_active;
    assign tx_done   = (ucnt == 1) || spur_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Print source: presents the head of pq and holds it until the handshake
    logic [7:0] pq[$];
    initial begin
        logic took;
        print_valid = 1'b0;
        print_data  = 8'h00;
        forever begin
            @(negedge clk);
            took = print_valid && print_ready;
            @(posedge clk);
            #2;
            if (took) void'(pq.pop_front());
            if (pq.size() > 0) begin
                print_valid = 1'b1;
                print_data  = pq[0];
            end else begin
                print_valid = 1'b0;
                print_data  = 8'h00;
            end
        end
    end

    // Reference model: one pending echo slot, a round-robin winner, and a
    // transaction that is open from its grant until its last tx_done.
    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;
    exp_t       sb[$];
    bit         m_free = 1'b1;
    bit         m_pend = 1'b0;
    bit         m_ovr  = 1'b0;
    bit         m_last_print = 1'b1;
    bit         m_need_lf = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_wr_due = 0;
    bit         exp_pr = 1'b0, exp_ovr = 1'b0, exp_busy = 1'b0;

    always @(negedge clk) begin
        bit g_echo, g_print;
        if (rst) begin
            m_free = 1'b1; m_pend = 1'b0; m_ovr = 1'b0; m_need_lf = 1'b0;
            m_last_print = !PRINT_FIRST;
            sb.delete();
            exp_pr = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_ovr  = m_ovr;
            exp_busy = !m_free || m_pend || print_valid;
            g_echo   = 1'b0;
            g_print  = 1'b0;
            if (m_free && !tx_active) begin
                if (m_pend && print_valid) begin
                    g_echo  = m_last_print;
                    g_print = !m_last_print;
                end else begin
                    g_echo  = m_pend;
                    g_print = !m_pend && print_valid;
                end
            end
            exp_pr = g_print;
            if (g_echo || g_print) begin
                sb.push_back('{g_echo ? m_byte : print_data, cyc + 1});
                m_free       = 1'b0;
                m_wr_due     = cyc + 1;
                m_need_lf    = ECHO_CRLF && g_echo && (m_byte == 8'h0D);
                m_last_print = g_print;
            end
            if (echo_valid) begin
                if (!m_pend || g_echo) begin
                    m_byte = echo_data;
                    m_pend = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (g_echo) begin
                m_pend = 1'b0;
            end
            if (tx_done && !m_free && cyc > m_wr_due) begin
                if (m_need_lf) begin
                    sb.push_back('{8'h0A, cyc + 1});
                    m_wr_due  = cyc + 1;
                    m_need_lf = 1'b0;
                end else begin
                    m_free = 1'b1;
                end
            end
        end
    end

    // Monitor
    logic [7:0] sent[$];
    int         wr_cnt = 0;
    int         pr_cnt = 0;
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            check("print_ready", print_ready, exp_pr);
            check("echo_overrun", echo_overrun, exp_ovr);
            check("busy", busy, exp_busy);
            if (print_ready) pr_cnt++;
            if (tx_wr) begin
                wr_cnt++;
                sent.push_back(tx_byte);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx_wr: got byte %0h, expected no frame (cycle %0d)",
                             tx_byte, cyc);
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", tx_byte, e.b);
                    check("tx_wr_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic check_reset();
        @(negedge clk);
        #2;
        check("rst_tx_wr", tx_wr, 0);
        check("rst_print_ready", print_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", echo_overrun, 0);
        check("rst_tx_byte", tx_byte, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset();
    endtask

    task automatic send_echo(input logic [7:0] b);
        @(posedge clk);
        #1;
        echo_valid = 1'b1;
        echo_data  = b;
        @(posedge clk);
        #1 echo_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            #2;
            ok = sb.size() == 0 && m_free && !m_pend && pq.size() == 0 && !print_valid &&
                 ucnt == 0;
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            echo_valid = ($urandom_range(5, 0) == 0);
            echo_data  = ($urandom_range(3, 0) == 0) ? 8'h0D : 8'($urandom_range(255, 0));
            if ($urandom_range(7, 0) == 0 && pq.size() < 4)
                pq.push_back(($urandom_range(7, 0) == 0) ? 8'h0D : 8'($urandom_range(255, 0)));
        end
        @(posedge clk);
        #1 echo_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [7:0] expq[$];
        int         w0, p0;
        bit         found;
        rst = 1'b1;
        echo_valid = 1'b0;
        echo_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();

        // Single echo
        send_echo(8'h41);
        wait_idle();
        check("single_busy", busy, 0);

        // CR echo with a print byte held behind it
        sent.delete();
        send_echo(8'h0D);
        repeat (2) @(posedge clk);
        #1 pq.push_back(8'h42);
        wait_idle();
        expq = {8'h0D};
        if (ECHO_CRLF) expq.push_back(8'h0A);
        expq.push_back(8'h42);
        check("crlf_count", sent.size(), expq.size());
        foreach (expq[i]) check("crlf_order", sent[i], expq[i]);

        // Overrun: three strobes during one long frame
        sent.delete();
        umin = 12;
        umax = 12;
        send_echo(8'h31);
        repeat (2) @(posedge clk);
        send_echo(8'h32);
        send_echo(8'h33);
        wait_idle();
        check("overrun_set", echo_overrun, 1);
        check("overrun_count", sent.size(), 2);
        check("overrun_first", sent[0], 8'h31);
        check("overrun_held", sent[1], 8'h32);
        umin = 2;
        umax = 6;
        send_echo(8'h44);
        wait_idle();
        check("overrun_sticky", echo_overrun, 1);

        // Spurious tx_done in IDLE, then requests while tx_active is forced high
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        ext_active = 1'b1;
        w0 = wr_cnt;
        pq.push_back(8'h66);
        send_echo(8'h55);
        repeat (15) @(posedge clk);
        check("no_wr_while_active", wr_cnt - w0, 0);
        #1 ext_active = 1'b0;
        wait_idle();
        check("active_release", wr_cnt - w0, 2);

        // Fairness from reset: simultaneous requests, then both kept busy
        do_reset();
        sent.delete();
        p0 = pr_cnt;
        @(posedge clk);
        #1;
        echo_valid = 1'b1;
        echo_data  = 8'h21;
        #2 pq.push_back(8'h22);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            echo_data = 8'h60 + 8'(i);
            if (i == 0) pq = {pq, 8'h50, 8'h51, 8'h52, 8'h53};
        end
        echo_valid = 1'b0;
        wait_idle();
        check("tie_first", sent[0], PRINT_FIRST ? 8'h22 : 8'h21);
        check("tie_second", sent[1], PRINT_FIRST ? 8'h21 : 8'h22);
        check("print_ready_pulses", pr_cnt - p0, 5);

        random_phase(1500);

        // Reset while the LF frame is in flight
        umin = 10;
        umax = 10;
        send_echo(8'h0D);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1 found = tx_wr && (tx_byte == 8'h0A);
        end
        check("lf_seen", found, ECHO_CRLF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        w0 = wr_cnt;
        check_reset();
        repeat (20) @(posedge clk);
        check("no_wr_after_rst", wr_cnt - w0, 0);
        umin = 2;
        umax = 6;
        wait_idle();

        random_phase(1500);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
